// File: rtl/nes_pad_responder_pkg.sv
// Shared definitions for the NES pad responder: button bit positions, FSM states
// and frame length.
package nes_pad_responder_pkg;

  localparam int unsigned NES_FRAME_BITS = 8;

  // Bit position of each button inside the 8-bit buttons bus / shift register.
  typedef enum int unsigned {
    NES_A      = 0,
    NES_B      = 1,
    NES_SELECT = 2,
    NES_START  = 3,
    NES_UP     = 4,
    NES_DOWN   = 5,
    NES_LEFT   = 6,
    NES_RIGHT  = 7
  } nes_button_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } nes_state_e;

endpackage

// File: rtl/nes_pad_responder_sync.sv
// Multi-flop synchronizer for an asynchronous strobe, followed by a one-flop
// rising-edge detector.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/nes_pad_responder.sv
// Gamepad side of the NES controller link: answers latch/pulse strobes and
// shifts out 8 active-low button bits, emulating a 4021 shift register.
module nes_pad_responder
  import nes_pad_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic        FILL_BIT       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buttons,
  input  logic       latch,
  input  logic       pulse,
  output logic       NESinputData,
  output logic       frameDone,
  output logic [3:0] shiftCount
);

  localparam int unsigned     TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_BIT   = 4'(NES_FRAME_BITS - 1);

  logic w_latch_level, w_latch_rise;
  logic w_pulse_level_unused, w_pulse_rise;

  nes_state_e    r_state, w_state_nxt;
  logic [7:0]    r_shreg, w_shreg_nxt;
  logic [3:0]    r_count, w_count_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_frame_done, w_frame_done_nxt;
  logic          w_timeout;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (latch),
    .o_level (w_latch_level),
    .o_rise  (w_latch_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (pulse),
    .o_level (w_pulse_level_unused),
    .o_rise  (w_pulse_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '1;
      r_count      <= '0;
      r_timer      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_count      <= w_count_nxt;
      r_timer      <= w_timer_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign w_timeout = (r_timer == TIMER_LAST);

  // Latch rise is tested before pulse rise everywhere, so a coincident pulse is dropped.
  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_count_nxt      = r_count;
    w_timer_nxt      = r_timer;
    w_frame_done_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_latch_rise) begin
          w_state_nxt = ST_LOAD;
          w_shreg_nxt = buttons;
          w_count_nxt = '0;
          w_timer_nxt = '0;
        end
      end
      ST_LOAD: begin
        w_shreg_nxt = buttons;
        w_count_nxt = '0;
        w_timer_nxt = '0;
        if (!w_latch_level) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_latch_rise) begin
          w_state_nxt = ST_LOAD;
          w_shreg_nxt = buttons;
          w_count_nxt = '0;
          w_timer_nxt = '0;
        end else if (w_pulse_rise) begin
          w_shreg_nxt = {1'b0, r_shreg[7:1]};
          w_count_nxt = r_count + 4'd1;
          w_timer_nxt = '0;
          if (r_count == LAST_BIT) begin
            w_state_nxt      = ST_DONE;
            w_frame_done_nxt = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_DONE: begin
        if (w_latch_rise) begin
          w_state_nxt = ST_LOAD;
          w_shreg_nxt = buttons;
          w_count_nxt = '0;
          w_timer_nxt = '0;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    NESinputData = 1'b1;
    unique case (r_state)
      ST_LOAD, ST_SHIFT: NESinputData = ~r_shreg[0];
      ST_DONE:           NESinputData = FILL_BIT;
      default:           NESinputData = 1'b1;
    endcase
  end

  assign frameDone  = r_frame_done;
  assign shiftCount = r_count;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed and randomized bench for nes_pad_responder, checked against a
// reader-level model of what each serial bit and bit count should be.
module tb_nes_pad_responder;

  localparam int unsigned TO   = 100;
  localparam logic        FILL = 1'b1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       latch = 1'b0;
  logic       pulse = 1'b0;
  logic [7:0] buttons = '0;
  logic       NESinputData;
  logic       frameDone;
  logic [3:0] shiftCount;

  int checks = 0;
  int errors = 0;
  int fd_seen = 0;

  nes_pad_responder #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO),
    .FILL_BIT       (FILL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .buttons      (buttons),
    .latch        (latch),
    .pulse        (pulse),
    .NESinputData (NESinputData),
    .frameDone    (frameDone),
    .shiftCount   (shiftCount)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frameDone === 1'b1) fd_seen <= fd_seen + 1;

  // Reader's view: bit k after k pulses is the inverted button k, then the fill level.
  function automatic logic exp_data(input logic [7:0] b, input int k);
    if (k < 8) return ~b[k];
    return FILL;
  endfunction

  function automatic logic [3:0] exp_count(input int k);
    return (k > 8) ? 4'd8 : 4'(k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_latch(input logic [7:0] b);
    buttons = b;
    latch = 1'b1;
    tick(8);
    latch = 1'b0;
    tick(8);
  endtask

  task automatic do_pulse();
    pulse = 1'b1;
    tick(4);
    pulse = 1'b0;
    tick(6);
  endtask

  task automatic run_frame(input logic [7:0] b, input string tag);
    int fd0;
    fd0 = fd_seen;
    do_latch(b);
    check($sformatf("%s data0", tag), 32'(NESinputData), 32'(exp_data(b, 0)));
    check($sformatf("%s count0", tag), 32'(shiftCount), 32'(exp_count(0)));
    for (int k = 1; k <= 9; k++) begin
      do_pulse();
      check($sformatf("%s data%0d", tag, k), 32'(NESinputData), 32'(exp_data(b, k)));
      check($sformatf("%s count%0d", tag, k), 32'(shiftCount), 32'(exp_count(k)));
    end
    check($sformatf("%s frameDone", tag), 32'(fd_seen - fd0), 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    int fd0;

    // Reset state
    tick(3);
    check("rst data", 32'(NESinputData), 32'd1);
    check("rst count", 32'(shiftCount), 32'd0);
    check("rst fd", 32'(frameDone), 32'd0);
    reset = 1'b0;
    tick(2);

    // A + Right frame, including ninth pulse into DONE
    run_frame(8'b1000_0001, "ar");
    // Timeout out of DONE returns count to 0
    tick(TO + 10);
    check("done_to count", 32'(shiftCount), 32'd0);
    check("done_to data", 32'(NESinputData), 32'd1);

    // Buttons changing mid-frame must not affect shifted bits
    do_latch(8'h00);
    buttons = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("frozen data%0d", k), 32'(NESinputData), 32'(exp_data(8'h00, k)));
      do_pulse();
    end

    // Mid-frame restart: no frameDone for the aborted frame
    fd0 = fd_seen;
    b = 8'($urandom);
    do_latch(b);
    repeat (3) do_pulse();
    check("abort data3", 32'(NESinputData), 32'(exp_data(b, 3)));
    do_latch(8'h02);
    check("restart data0", 32'(NESinputData), 32'd1);
    check("restart count0", 32'(shiftCount), 32'd0);
    do_pulse();
    check("restart data1", 32'(NESinputData), 32'd0);
    check("restart fd none", 32'(fd_seen - fd0), 32'd0);
    repeat (7) do_pulse();
    check("restart fd one", 32'(fd_seen - fd0), 32'd1);

    // No pulses after latch: timeout to IDLE
    do_latch(8'h01);
    tick(TO - 25);
    check("to early data", 32'(NESinputData), 32'd0);
    tick(35);
    check("to data", 32'(NESinputData), 32'd1);
    check("to count", 32'(shiftCount), 32'd0);
    do_pulse();
    check("idle pulse count", 32'(shiftCount), 32'd0);

    // Timeout after a partial frame
    do_latch(8'h01);
    repeat (2) do_pulse();
    check("to2 count", 32'(shiftCount), 32'd2);
    tick(TO - 25);
    check("to2 hold", 32'(shiftCount), 32'd2);
    tick(35);
    check("to2 count0", 32'(shiftCount), 32'd0);

    // Latch and pulse together, pulses during latch, then reset mid-frame
    b = {8'($urandom)} & 8'hFC | 8'h01;
    do_latch(b);
    do_pulse();
    check("coinc pre count", 32'(shiftCount), 32'd1);
    latch = 1'b1;
    pulse = 1'b1;
    tick(4);
    pulse = 1'b0;
    tick(3);
    pulse = 1'b1;
    tick(4);
    pulse = 1'b0;
    latch = 1'b0;
    tick(8);
    check("coinc count", 32'(shiftCount), 32'd0);
    check("coinc data", 32'(NESinputData), 32'(exp_data(b, 0)));
    repeat (4) do_pulse();
    check("pre rst count", 32'(shiftCount), 32'd4);
    check("pre rst data", 32'(NESinputData), 32'(exp_data(b, 4)));
    reset = 1'b1;
    tick(1);
    check("midrst data", 32'(NESinputData), 32'd1);
    check("midrst count", 32'(shiftCount), 32'd0);
    check("midrst fd", 32'(frameDone), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Randomized frames
    for (int i = 0; i < 6; i++) begin
      run_frame(8'($urandom), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
